// File: rtl/crossbar_rr_pkt.sv
// -----------------------------------------------------------------------------
// crossbar_rr_pkt
//   Registered PORTS x PORTS packet crossbar with valid/ready handshakes on
//   every port. Each output runs its own round-robin arbiter and holds a
//   wormhole lock from the head flit to the last flit of a packet, so packets
//   are never interleaved on an output. Each output has one register stage,
//   giving a one-cycle latency and up to one flit per cycle per output.
//   Head flits addressed to a non-existent output (dest >= PORTS) are
//   accepted and discarded together with the rest of their packet.
//
// Parameters
//   PORTS   number of input and output ports (>= 2, any value)
//   WIDTH   flit payload width
//   DEST_W  width of destination/source indices (derived, min 1)
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   per-input flit valid
//   in_data_i    per-input payload
//   in_dest_i    per-input destination output (used on head flits only)
//   in_last_i    per-input last-flit-of-packet flag
//   in_ready_o   per-input accept (flit moves when valid && ready)
//   out_valid_o  per-output registered valid
//   out_data_o   per-output registered payload
//   out_last_o   per-output registered last flag
//   out_src_o    per-output registered source input index
//   out_ready_i  per-output downstream ready
//   drop_o       per-input 1-cycle pulse after a bad-destination head flit
//
// Optional build macro CROSSBAR_RR_PKT_STATS_EN adds:
//   stat_clr_i   synchronous clear of the packet counters (wins over count)
//   stat_pkts_o  per-output saturating 16-bit count of completed packets
// -----------------------------------------------------------------------------
module crossbar_rr_pkt #(
  parameter  int PORTS  = 4,
  parameter  int WIDTH  = 8,
  localparam int DEST_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [PORTS-1:0]                   in_valid_i,
  input  logic [PORTS-1:0][WIDTH-1:0]        in_data_i,
  input  logic [PORTS-1:0][DEST_W-1:0]       in_dest_i,
  input  logic [PORTS-1:0]                   in_last_i,
  output logic [PORTS-1:0]                   in_ready_o,
  output logic [PORTS-1:0]                   out_valid_o,
  output logic [PORTS-1:0][WIDTH-1:0]        out_data_o,
  output logic [PORTS-1:0]                   out_last_o,
  output logic [PORTS-1:0][DEST_W-1:0]       out_src_o,
  input  logic [PORTS-1:0]                   out_ready_i,
  output logic [PORTS-1:0]                   drop_o
`ifdef CROSSBAR_RR_PKT_STATS_EN
  ,
  input  logic                               stat_clr_i,
  output logic [PORTS-1:0][15:0]             stat_pkts_o
`endif
);

  localparam int DW1 = DEST_W + 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  // Per-output state
  state_t                      r_state  [PORTS];
  logic [PORTS-1:0][DEST_W-1:0] r_owner;
  logic [PORTS-1:0][DEST_W-1:0] r_rr_ptr;
  logic [PORTS-1:0]             r_out_valid;
  logic [PORTS-1:0][WIDTH-1:0]  r_out_data;
  logic [PORTS-1:0]             r_out_last;
  logic [PORTS-1:0][DEST_W-1:0] r_out_src;

  // Per-input state
  logic [PORTS-1:0]             r_in_drop;
  logic [PORTS-1:0]             r_drop;

  logic [PORTS-1:0]             w_in_locked;
  logic [PORTS-1:0]             w_dest_bad;
  logic [PORTS-1:0]             w_drop_acc;
  logic [PORTS-1:0][PORTS-1:0]  w_cand;      // [output][input]
  logic [PORTS-1:0]             w_can_load;
  logic [PORTS-1:0]             w_sel_vld;
  logic [PORTS-1:0][DEST_W-1:0] w_sel;
  logic [PORTS-1:0]             w_xfer;
  logic [PORTS-1:0]             w_xfer_last;

  // The extra bit keeps the compare meaningful when PORTS is a power of two.
  function automatic logic f_dest_bad(input logic [DEST_W-1:0] d);
    return ({1'b0, d} >= DW1'(PORTS));
  endfunction

  function automatic logic [DEST_W-1:0] f_wrap_inc(input logic [DEST_W-1:0] v);
    if (int'(v) >= PORTS - 1) return '0;
    return v + DEST_W'(1);
  endfunction

  // An input is locked while some output holds it as wormhole owner.
  always_comb begin
    w_in_locked = '0;
    for (int j = 0; j < PORTS; j++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (r_state[j] == S_LOCKED && r_owner[j] == DEST_W'(i)) w_in_locked[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_dest_bad = '0;
    w_drop_acc = '0;
    w_cand     = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_dest_bad[i] = f_dest_bad(in_dest_i[i]);
      // Inputs in DROP swallow everything up to the last flit, whatever dest says.
      w_drop_acc[i] = in_valid_i[i] && !w_in_locked[i] && (r_in_drop[i] || w_dest_bad[i]);
      for (int j = 0; j < PORTS; j++) begin
        w_cand[j][i] = in_valid_i[i] && !w_in_locked[i] && !r_in_drop[i] &&
                       !w_dest_bad[i] && (in_dest_i[i] == DEST_W'(j));
      end
    end
  end

  // Per-output selection: the owner when locked, else round-robin from rr_ptr.
  always_comb begin
    int   idx;
    logic found;
    idx         = 0;
    found       = 1'b0;
    w_can_load  = '0;
    w_sel_vld   = '0;
    w_sel       = '0;
    w_xfer      = '0;
    w_xfer_last = '0;
    for (int j = 0; j < PORTS; j++) begin
      w_can_load[j] = !r_out_valid[j] || out_ready_i[j];
      w_sel[j]      = r_owner[j];
      found         = 1'b0;
      if (r_state[j] == S_LOCKED) begin
        found = in_valid_i[r_owner[j]];
      end else begin
        for (int k = 0; k < PORTS; k++) begin
          idx = int'(r_rr_ptr[j]) + k;
          if (idx >= PORTS) idx = idx - PORTS;
          if (!found && w_cand[j][idx]) begin
            w_sel[j] = DEST_W'(idx);
            found    = 1'b1;
          end
        end
      end
      w_sel_vld[j]   = found;
      w_xfer[j]      = found && w_can_load[j];
      w_xfer_last[j] = in_last_i[w_sel[j]];
    end
  end

  always_comb begin
    in_ready_o = w_drop_acc;
    for (int j = 0; j < PORTS; j++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (w_xfer[j] && w_sel[j] == DEST_W'(i)) in_ready_o[i] = 1'b1;
      end
    end
  end

  // ---- output register stage / arbitration and lock state ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int j = 0; j < PORTS; j++) r_state[j] <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_out_last  <= '0;
      r_out_src   <= '0;
      r_in_drop   <= '0;
      r_drop      <= '0;
    end else begin
      for (int j = 0; j < PORTS; j++) begin
        if (w_xfer[j]) begin
          r_out_valid[j] <= 1'b1;
          r_out_data[j]  <= in_data_i[w_sel[j]];
          r_out_last[j]  <= w_xfer_last[j];
          r_out_src[j]   <= w_sel[j];
          if (w_xfer_last[j]) begin
            // Pointer moves only when a packet completes.
            r_state[j]  <= S_IDLE;
            r_rr_ptr[j] <= f_wrap_inc(w_sel[j]);
          end else begin
            r_state[j] <= S_LOCKED;
            r_owner[j] <= w_sel[j];
          end
        end else if (out_ready_i[j]) begin
          r_out_valid[j] <= 1'b0;
        end
      end
      for (int i = 0; i < PORTS; i++) begin
        // Pulse only for the head flit; body flits of a dropped packet are silent.
        r_drop[i] <= w_drop_acc[i] && !r_in_drop[i];
        if (w_drop_acc[i]) r_in_drop[i] <= !in_last_i[i];
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;
  assign out_src_o   = r_out_src;
  assign drop_o      = r_drop;

`ifdef CROSSBAR_RR_PKT_STATS_EN
  logic [PORTS-1:0][15:0] r_stat_pkts;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat_pkts <= '0;
    end else if (stat_clr_i) begin
      r_stat_pkts <= '0;
    end else begin
      for (int j = 0; j < PORTS; j++) begin
        if (w_xfer[j] && w_xfer_last[j] && r_stat_pkts[j] != 16'hFFFF)
          r_stat_pkts[j] <= r_stat_pkts[j] + 16'd1;
      end
    end
  end

  assign stat_pkts_o = r_stat_pkts;
`endif

endmodule

// File: tb/tb_crossbar_rr_pkt.sv
module tb_crossbar_rr_pkt;
  localparam int P  = 4;
  localparam int W  = 8;
  localparam int DW = 2;
  localparam int P3 = 3;

  typedef logic [10:0] ent_t;  // {src[1:0], last, data[7:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 4-port instance
  logic [P-1:0]         in_valid, in_last, in_ready, out_valid, out_last, out_ready, drop;
  logic [P-1:0][W-1:0]  in_data, out_data;
  logic [P-1:0][DW-1:0] in_dest, out_src;

  // 3-port instance (for the bad-destination case)
  logic [P3-1:0]         b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_last, b_out_ready, b_drop;
  logic [P3-1:0][W-1:0]  b_in_data, b_out_data;
  logic [P3-1:0][DW-1:0] b_in_dest, b_out_src;

`ifdef CROSSBAR_RR_PKT_STATS_EN
  logic                  stat_clr;
  logic [P-1:0][15:0]    stat_pkts;
  logic [P3-1:0][15:0]   b_stat_pkts;
`endif

  crossbar_rr_pkt #(.PORTS(P), .WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_dest_i(in_dest), .in_last_i(in_last),
    .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last), .out_src_o(out_src),
    .out_ready_i(out_ready), .drop_o(drop)
`ifdef CROSSBAR_RR_PKT_STATS_EN
    , .stat_clr_i(stat_clr), .stat_pkts_o(stat_pkts)
`endif
  );

  crossbar_rr_pkt #(.PORTS(P3), .WIDTH(W)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(b_in_valid), .in_data_i(b_in_data), .in_dest_i(b_in_dest), .in_last_i(b_in_last),
    .in_ready_o(b_in_ready),
    .out_valid_o(b_out_valid), .out_data_o(b_out_data), .out_last_o(b_out_last), .out_src_o(b_out_src),
    .out_ready_i(b_out_ready), .drop_o(b_drop)
`ifdef CROSSBAR_RR_PKT_STATS_EN
    , .stat_clr_i(stat_clr), .stat_pkts_o(b_stat_pkts)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;
  ent_t exp_q [P][$];
  int b_drops = 0;
  int b_outs  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic exp_push(input int j, input logic [1:0] src, input logic lst, input logic [7:0] d);
    exp_q[j].push_back({src, lst, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake cycle.
  task automatic send(input int i, input logic [7:0] d, input logic [1:0] dst, input logic lst);
    int n;
    n = 0;
    in_data[i] = d; in_dest[i] = dst; in_last[i] = lst; in_valid[i] = 1'b1;
    @(negedge clk);
    while (!in_ready[i] && n < 100) begin n++; @(negedge clk); end
    if (!in_ready[i]) begin
      n_vec++; n_fail++;
      $display("FAIL send_in%0d: in_ready got 0, required 1 within 100 cycles", i);
    end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic send3(input int i, input logic [7:0] d, input logic [1:0] dst, input logic lst);
    int n;
    n = 0;
    b_in_data[i] = d; b_in_dest[i] = dst; b_in_last[i] = lst; b_in_valid[i] = 1'b1;
    @(negedge clk);
    while (!b_in_ready[i] && n < 100) begin n++; @(negedge clk); end
    if (!b_in_ready[i]) begin
      n_vec++; n_fail++;
      $display("FAIL send3_in%0d: in_ready got 0, required 1 within 100 cycles", i);
    end
    @(posedge clk); #1;
    b_in_valid[i] = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks held flits stay put.
  ent_t       held [P];
  logic [P-1:0] held_v = '0;
  always @(negedge clk) begin
    ent_t act, e;
    if (!rst_n) begin
      held_v = '0;
    end else begin
      for (int j = 0; j < P; j++) begin
        act = {out_src[j], out_last[j], out_data[j]};
        if (held_v[j] && out_valid[j]) check($sformatf("hold_out%0d", j), act, held[j]);
        if (out_valid[j] && out_ready[j]) begin
          if (exp_q[j].size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL out%0d_unexpected: got %0h, required no flit", j, act);
          end else begin
            e = exp_q[j].pop_front();
            check($sformatf("out%0d_flit", j), act, e);
          end
        end
        held_v[j] = out_valid[j] && !out_ready[j];
        held[j]   = act;
      end
      b_drops += $countones(b_drop);
      b_outs  += $countones(b_out_valid);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = '0; in_last = '0; in_data = '0; in_dest = '0; out_ready = '1;
    b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_in_dest = '0; b_out_ready = '1;
`ifdef CROSSBAR_RR_PKT_STATS_EN
    stat_clr = 1'b0;
`endif
    idle(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_drop",      drop, 0);
    check("rst_in_ready",  in_ready, 0);
    rst_n = 1'b1;
    idle(1);

    // Single flit in0 -> out2
    exp_push(2, 2'd0, 1'b1, 8'hA5);
    send(0, 8'hA5, 2'd2, 1'b1);
    check("single_latency_valid", out_valid[2], 1);
    check("single_src", out_src[2], 0);
    idle(2);

    // Contention on out1 from in0, in1, in3: grant order 0,1,3,0,1,3
    exp_push(1, 2'd0, 1'b1, 8'h10); exp_push(1, 2'd1, 1'b1, 8'h20); exp_push(1, 2'd3, 1'b1, 8'h30);
    exp_push(1, 2'd0, 1'b1, 8'h11); exp_push(1, 2'd1, 1'b1, 8'h21); exp_push(1, 2'd3, 1'b1, 8'h31);
    fork
      begin send(0, 8'h10, 2'd1, 1'b1); send(0, 8'h11, 2'd1, 1'b1); end
      begin send(1, 8'h20, 2'd1, 1'b1); send(1, 8'h21, 2'd1, 1'b1); end
      begin send(3, 8'h30, 2'd1, 1'b1); send(3, 8'h31, 2'd1, 1'b1); end
    join
    idle(2);

    // Wormhole: in2 3-flit packet to out0 (body dests ignored), in1 waits
    exp_push(0, 2'd2, 1'b0, 8'h40); exp_push(0, 2'd2, 1'b0, 8'h41);
    exp_push(0, 2'd2, 1'b1, 8'h42); exp_push(0, 2'd1, 1'b1, 8'h50);
    fork
      begin send(2, 8'h40, 2'd0, 1'b0); send(2, 8'h41, 2'd3, 1'b0); send(2, 8'h42, 2'd1, 1'b1); end
      begin idle(1); send(1, 8'h50, 2'd0, 1'b1); end
    join
    idle(2);

    // Backpressure on out3
    out_ready[3] = 1'b0;
    exp_push(3, 2'd0, 1'b1, 8'h77); exp_push(3, 2'd1, 1'b1, 8'h88);
    send(0, 8'h77, 2'd3, 1'b1);
    fork
      send(1, 8'h88, 2'd3, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready1", in_ready[1], 0);
          check("bp_out_data3", out_data[3], 8'h77);
        end
        @(posedge clk); #1;
        out_ready[3] = 1'b1;
      end
    join
    idle(3);

    // Reset in the middle of a packet from in3 to out0
    out_ready[0] = 1'b0;
    send(3, 8'h60, 2'd0, 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_drop", drop, 0);
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    idle(1);
    exp_push(0, 2'd3, 1'b1, 8'h99);
    send(3, 8'h99, 2'd0, 1'b1);
`ifdef CROSSBAR_RR_PKT_STATS_EN
    check("stats_out0", stat_pkts[0], 1);
`endif
    exp_push(0, 2'd0, 1'b1, 8'hAA);
    send(0, 8'hAA, 2'd0, 1'b1);
    idle(2);

    // Bad destination on the 3-port build: whole packet discarded, one drop pulse
    b_drops = 0; b_outs = 0;
    send3(0, 8'hC1, 2'd3, 1'b0);
    send3(0, 8'hC2, 2'd0, 1'b0);
    send3(0, 8'hC3, 2'd0, 1'b1);
    idle(3);
    check("drop_pulses", b_drops, 1);
    check("drop_no_out", b_outs, 0);
    send3(0, 8'hC4, 2'd1, 1'b1);
    check("after_drop_valid", b_out_valid[1], 1);
    check("after_drop_data", b_out_data[1], 8'hC4);
    idle(3);

    for (int j = 0; j < P; j++) check($sformatf("queue%0d_drained", j), exp_q[j].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
